// File: rtl/flop_fifo_pkg.sv
// Shared types and helpers for the flop FIFO pop-side downsizer.
package flop_fifo_pkg;

    typedef logic [31:0] stat_cnt_t;

    localparam stat_cnt_t STAT_SAT = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } ds_state_t;

    // Beat index needs at least one bit even when a word is a single beat.
    function automatic int beat_idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/flop_fifo_pop_downsizer_if.sv
// FIFO pop side plus narrow beat stream of the downsizer.
// master = FIFO/downstream environment, slave = the downsizer itself.
interface flop_fifo_pop_downsizer_if #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64
);

    localparam int IDX_W = flop_fifo_pkg::beat_idx_width(IN_WIDTH / OUT_WIDTH);

    logic                 fifo_data_valid;
    logic [IN_WIDTH-1:0]  fifo_pop_data;
    logic                 fifo_pop;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [IDX_W-1:0]     out_beat_idx;

    modport master (
        output fifo_data_valid,
        output fifo_pop_data,
        output out_ready,
        input  fifo_pop,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_beat_idx
    );

    modport slave (
        input  fifo_data_valid,
        input  fifo_pop_data,
        input  out_ready,
        output fifo_pop,
        output out_valid,
        output out_data,
        output out_last,
        output out_beat_idx
    );

endinterface

// File: rtl/flop_fifo_ds_stats.sv
// Saturating word and backpressure counters for the pop-side downsizer.
module flop_fifo_ds_stats
    import flop_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      sync_rst,
    input  logic      word_inc,
    input  logic      stall_inc,
    output stat_cnt_t stat_words,
    output stat_cnt_t stat_stall
);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (word_inc && (stat_words != STAT_SAT)) begin
                stat_words <= stat_words + 32'd1;
            end
            if (stall_inc && (stat_stall != STAT_SAT)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/flop_fifo_pop_downsizer.sv
// Pops wide FIFO words and replays them as RATIO narrow beats with a last marker.
// Optional statistics counters are enabled with FLOP_FIFO_POP_DS_STATS_EN.
module flop_fifo_pop_downsizer
    import flop_fifo_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    flop_fifo_pop_downsizer_if.slave   bus,
    output stat_cnt_t                  stat_words,
    output stat_cnt_t                  stat_stall
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = beat_idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    ds_state_t                        state_q;
    ds_state_t                        state_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0]  hold_q;
    logic [IDX_W-1:0]                 beat_idx_q;
    logic [IDX_W-1:0]                 beat_idx_d;
    logic [IDX_W-1:0]                 slice_sel;
    logic                             hold_valid;
    logic                             beat_xfer;
    logic                             is_last;
    logic                             word_done;
    logic                             pop;

    assign hold_valid = (state_q == ST_HOLD);
    assign is_last    = (beat_idx_q == LAST_IDX);
    assign beat_xfer  = hold_valid & bus.out_ready;
    assign word_done  = beat_xfer & is_last;
    // Popping on the final accepted beat keeps the stream gap-free across words.
    assign pop        = bus.fifo_data_valid & (~hold_valid | word_done) & ~sync_rst;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= ST_EMPTY;
            beat_idx_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            if (pop) begin
                hold_q <= bus.fifo_pop_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        case (state_q)
            ST_EMPTY: begin
                if (pop) begin
                    state_d    = ST_HOLD;
                    beat_idx_d = '0;
                end
            end
            ST_HOLD: begin
                if (word_done) begin
                    state_d    = pop ? ST_HOLD : ST_EMPTY;
                    beat_idx_d = '0;
                end else if (beat_xfer) begin
                    beat_idx_d = beat_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d    = ST_EMPTY;
                beat_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        slice_sel        = MSB_FIRST ? (LAST_IDX - beat_idx_q) : beat_idx_q;
        bus.fifo_pop     = pop;
        bus.out_valid    = hold_valid;
        bus.out_data     = hold_q[slice_sel];
        bus.out_last     = hold_valid & is_last;
        bus.out_beat_idx = beat_idx_q;
    end

`ifdef FLOP_FIFO_POP_DS_STATS_EN
    flop_fifo_ds_stats u_stats (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .word_inc   (pop),
        .stall_inc  (hold_valid & ~bus.out_ready),
        .stat_words (stat_words),
        .stat_stall (stat_stall)
    );
`else
    assign stat_words = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_flop_fifo_pop_downsizer.sv
// Bench for flop_fifo_pop_downsizer: LSB-first 4:1, MSB-first 4:1 and 1:1 instances
// fed from queue-modelled FIFOs, with table vectors, directed corners and a random scoreboard.
module tb_flop_fifo_pop_downsizer;
    import flop_fifo_pkg::*;

    localparam int NDUT = 3;
`ifdef FLOP_FIFO_POP_DS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [255:0] data;
        logic         last;
        int           idx;
    } beat_t;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        push;
        logic        exp_pop;
        logic        exp_valid;
        logic        chk_data;
        logic [63:0] exp_data;
        logic        exp_last;
        int          exp_idx;
    } vec_t;

    logic clk;
    logic sync_rst;
    logic ready;
    int   n_vec;
    int   n_err;

    logic [255:0] wq    [NDUT][$];
    beat_t        exp_q [NDUT][$];

    logic         s_pop   [NDUT];
    logic         s_dv    [NDUT];
    logic         s_valid [NDUT];
    logic         s_last  [NDUT];
    logic [255:0] s_data  [NDUT];
    int           s_idx   [NDUT];

    logic         p_valid [NDUT];
    logic         p_last  [NDUT];
    logic [255:0] p_data  [NDUT];
    int           p_idx   [NDUT];
    logic         p_ready;

    stat_cnt_t words_lsb, stall_lsb, words_msb, stall_msb, words_r1, stall_r1;

    flop_fifo_pop_downsizer_if #(.IN_WIDTH(256), .OUT_WIDTH(64))  if_lsb ();
    flop_fifo_pop_downsizer_if #(.IN_WIDTH(256), .OUT_WIDTH(64))  if_msb ();
    flop_fifo_pop_downsizer_if #(.IN_WIDTH(256), .OUT_WIDTH(256)) if_r1 ();

    flop_fifo_pop_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(64), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .sync_rst(sync_rst), .bus(if_lsb), .stat_words(words_lsb), .stat_stall(stall_lsb)
    );
    flop_fifo_pop_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(64), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .sync_rst(sync_rst), .bus(if_msb), .stat_words(words_msb), .stat_stall(stall_msb)
    );
    flop_fifo_pop_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(256), .MSB_FIRST(1'b0)) u_r1 (
        .clk(clk), .sync_rst(sync_rst), .bus(if_r1), .stat_words(words_r1), .stat_stall(stall_r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Expected beats come straight from slicing the word as the stream order defines it.
    task automatic push_word(input int d, input logic [255:0] w);
        int           ratio;
        int           ow;
        int           s;
        logic [255:0] mask;
        beat_t        b;
        ratio = (d == 2) ? 1 : 4;
        ow    = (d == 2) ? 256 : 64;
        mask  = (ow == 256) ? {256{1'b1}} : ((256'd1 << ow) - 256'd1);
        wq[d].push_back(w);
        for (int k = 0; k < ratio; k++) begin
            s      = (d == 1) ? (ratio - 1 - k) : k;
            b.data = (w >> (s * ow)) & mask;
            b.last = (k == ratio - 1);
            b.idx  = k;
            exp_q[d].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        if_lsb.fifo_data_valid = (wq[0].size() != 0);
        if_lsb.fifo_pop_data   = (wq[0].size() != 0) ? wq[0][0] : rand_word();
        if_msb.fifo_data_valid = (wq[1].size() != 0);
        if_msb.fifo_pop_data   = (wq[1].size() != 0) ? wq[1][0] : rand_word();
        if_r1.fifo_data_valid  = (wq[2].size() != 0);
        if_r1.fifo_pop_data    = (wq[2].size() != 0) ? wq[2][0] : rand_word();
        if_lsb.out_ready = ready;
        if_msb.out_ready = ready;
        if_r1.out_ready  = ready;
    endtask

    task automatic sample();
        s_pop[0] = if_lsb.fifo_pop; s_dv[0] = if_lsb.fifo_data_valid; s_valid[0] = if_lsb.out_valid;
        s_last[0] = if_lsb.out_last; s_data[0] = 256'(if_lsb.out_data); s_idx[0] = int'(if_lsb.out_beat_idx);
        s_pop[1] = if_msb.fifo_pop; s_dv[1] = if_msb.fifo_data_valid; s_valid[1] = if_msb.out_valid;
        s_last[1] = if_msb.out_last; s_data[1] = 256'(if_msb.out_data); s_idx[1] = int'(if_msb.out_beat_idx);
        s_pop[2] = if_r1.fifo_pop; s_dv[2] = if_r1.fifo_data_valid; s_valid[2] = if_r1.out_valid;
        s_last[2] = if_r1.out_last; s_data[2] = if_r1.out_data; s_idx[2] = int'(if_r1.out_beat_idx);
    endtask

    task automatic step_begin();
        drive_inputs();
        @(negedge clk);
        sample();
    endtask

    task automatic step_end();
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (s_pop[d] && (wq[d].size() != 0)) void'(wq[d].pop_front());
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int d = 0; d < NDUT; d++) begin
            wq[d].delete();
            exp_q[d].delete();
            p_valid[d] = 1'b0;
        end
        sync_rst = 1'b1;
        ready    = 1'b1;
        repeat (n) begin
            step_begin();
            step_end();
        end
        sync_rst = 1'b0;
        p_ready  = 1'b1;
    endtask

    task automatic scoreboard(input int cyc);
        beat_t b;
        for (int d = 0; d < NDUT; d++) begin
            check_bit($sformatf("pop_needs_dv d%0d c%0d", d, cyc), s_pop[d] & ~s_dv[d], 1'b0);
            if (p_valid[d] && !p_ready) begin
                check_bit($sformatf("hold_valid d%0d c%0d", d, cyc), s_valid[d], 1'b1);
                check_val($sformatf("hold_data d%0d c%0d", d, cyc), s_data[d], p_data[d]);
                check_bit($sformatf("hold_last d%0d c%0d", d, cyc), s_last[d], p_last[d]);
                check_int($sformatf("hold_idx d%0d c%0d", d, cyc), s_idx[d], p_idx[d]);
            end
            if (s_valid[d] && ready) begin
                if (exp_q[d].size() == 0) begin
                    check_int($sformatf("spurious_beat d%0d c%0d", d, cyc), 1, 0);
                end else begin
                    b = exp_q[d].pop_front();
                    check_val($sformatf("beat_data d%0d c%0d", d, cyc), s_data[d], b.data);
                    check_bit($sformatf("beat_last d%0d c%0d", d, cyc), s_last[d], b.last);
                    check_int($sformatf("beat_idx d%0d c%0d", d, cyc), s_idx[d], b.idx);
                end
            end
            p_valid[d] = s_valid[d];
            p_data[d]  = s_data[d];
            p_last[d]  = s_last[d];
            p_idx[d]   = s_idx[d];
        end
        p_ready = ready;
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic push, input logic pop,
                                input logic valid, input logic chk, input logic [63:0] data,
                                input logic last, input int idx);
        vec_t v;
        v.rst = rst; v.ready = rdy; v.push = push; v.exp_pop = pop; v.exp_valid = valid;
        v.chk_data = chk; v.exp_data = data; v.exp_last = last; v.exp_idx = idx;
        return v;
    endfunction

    task automatic applyStimulus();
        vec_t         vecs [20];
        logic [255:0] word_w;
        logic [255:0] word_w2;
        logic [255:0] word_a;
        logic [255:0] word_b;
        logic [255:0] tmp;
        int           left;

        word_w  = {64'h4, 64'h3, 64'h2, 64'h1};
        word_w2 = {64'h14, 64'h13, 64'h12, 64'h11};

        // Reset with data waiting, one word at full rate, then one word with a 5-cycle stall on beat 2.
        vecs[0]  = mk(1, 1, 1, 0, 0, 0, 64'h0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 1, 64'h0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 1, 64'h0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 1, 0, 1, 64'h0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 1, 1, 64'h1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 1, 1, 64'h2, 0, 1);
        vecs[6]  = mk(0, 1, 0, 0, 1, 1, 64'h3, 0, 2);
        vecs[7]  = mk(0, 1, 0, 0, 1, 1, 64'h4, 1, 3);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 64'h0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 1, 0, 0, 64'h0, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 1, 1, 64'h1, 0, 0);
        for (int i = 11; i <= 15; i++) vecs[i] = mk(0, 0, 0, 0, 1, 1, 64'h2, 0, 1);
        vecs[16] = mk(0, 1, 0, 0, 1, 1, 64'h2, 0, 1);
        vecs[17] = mk(0, 1, 0, 0, 1, 1, 64'h3, 0, 2);
        vecs[18] = mk(0, 1, 0, 0, 1, 1, 64'h4, 1, 3);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 64'h0, 0, 0);

        do_reset(1);
        for (int r = 0; r < 20; r++) begin
            sync_rst = vecs[r].rst;
            ready    = vecs[r].ready;
            if (vecs[r].push) push_word(0, word_w);
            step_begin();
            check_bit($sformatf("tbl_pop r%0d", r), s_pop[0], vecs[r].exp_pop);
            check_bit($sformatf("tbl_valid r%0d", r), s_valid[0], vecs[r].exp_valid);
            check_bit($sformatf("tbl_last r%0d", r), s_last[0], vecs[r].exp_last);
            check_int($sformatf("tbl_idx r%0d", r), s_idx[0], vecs[r].exp_idx);
            if (vecs[r].chk_data) check_val($sformatf("tbl_data r%0d", r), s_data[0], 256'(vecs[r].exp_data));
            step_end();
        end
        check_val("stall_count", 256'(stall_lsb), STATS ? 256'd5 : 256'd0);
        check_val("word_count", 256'(words_lsb), STATS ? 256'd2 : 256'd0);

        // Three words back to back: 12 beats without a gap, pops on relative cycles 0, 4, 8.
        do_reset(1);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) tmp[b*64 +: 64] = 64'(16 * (w + 1) + b + 1);
            push_word(0, tmp);
        end
        for (int c = 0; c < 14; c++) begin
            step_begin();
            check_bit($sformatf("b2b_pop c%0d", c), s_pop[0], (c == 0) || (c == 4) || (c == 8));
            check_bit($sformatf("b2b_valid c%0d", c), s_valid[0], (c >= 1) && (c <= 12));
            if ((c >= 1) && (c <= 12)) begin
                check_val($sformatf("b2b_data c%0d", c), s_data[0], 256'(16 * ((c - 1) / 4 + 1) + (c - 1) % 4 + 1));
                check_bit($sformatf("b2b_last c%0d", c), s_last[0], ((c - 1) % 4) == 3);
                check_int($sformatf("b2b_idx c%0d", c), s_idx[0], (c - 1) % 4);
            end
            step_end();
        end

        // Reset one cycle after beat 1 is accepted: the rest of the word is dropped.
        do_reset(1);
        push_word(0, word_w);
        step_begin();
        check_bit("mid_pop0", s_pop[0], 1'b1);
        step_end();
        step_begin();
        check_val("mid_beat1", s_data[0], 256'h1);
        step_end();
        sync_rst = 1'b1;
        push_word(0, word_w2);
        step_begin();
        check_bit("mid_pop_in_reset", s_pop[0], 1'b0);
        step_end();
        sync_rst = 1'b0;
        step_begin();
        check_bit("mid_valid_after_rst", s_valid[0], 1'b0);
        check_bit("mid_pop_after_rst", s_pop[0], 1'b1);
        check_val("mid_words_after_rst", 256'(words_lsb), 256'd0);
        step_end();
        step_begin();
        check_bit("mid_next_valid", s_valid[0], 1'b1);
        check_val("mid_next_data", s_data[0], 256'h11);
        check_int("mid_next_idx", s_idx[0], 0);
        step_end();

        // MSB-first ordering and the single-beat configuration.
        do_reset(1);
        word_a = rand_word();
        word_b = rand_word();
        push_word(1, word_w);
        push_word(2, word_a);
        push_word(2, word_b);
        for (int c = 0; c < 6; c++) begin
            step_begin();
            check_bit($sformatf("msb_pop c%0d", c), s_pop[1], c == 0);
            check_bit($sformatf("msb_valid c%0d", c), s_valid[1], (c >= 1) && (c <= 4));
            if ((c >= 1) && (c <= 4)) begin
                check_val($sformatf("msb_data c%0d", c), s_data[1], 256'(5 - c));
                check_int($sformatf("msb_idx c%0d", c), s_idx[1], c - 1);
                check_bit($sformatf("msb_last c%0d", c), s_last[1], c == 4);
            end
            check_bit($sformatf("r1_pop c%0d", c), s_pop[2], (c == 0) || (c == 1));
            check_bit($sformatf("r1_valid c%0d", c), s_valid[2], (c == 1) || (c == 2));
            if ((c == 1) || (c == 2)) begin
                check_val($sformatf("r1_data c%0d", c), s_data[2], (c == 1) ? word_a : word_b);
                check_bit($sformatf("r1_last c%0d", c), s_last[2], 1'b1);
                check_int($sformatf("r1_idx c%0d", c), s_idx[2], 0);
            end
            step_end();
        end
        check_val("msb_words", 256'(words_msb), STATS ? 256'd1 : 256'd0);
        check_val("r1_words", 256'(words_r1), STATS ? 256'd2 : 256'd0);
        check_val("msb_stall", 256'(stall_msb), 256'd0);
        check_val("r1_stall", 256'(stall_r1), 256'd0);

        // Random traffic and backpressure on all three instances.
        do_reset(1);
        for (int c = 0; c < 1500; c++) begin
            ready = ($urandom_range(0, 99) < 70);
            for (int d = 0; d < NDUT; d++) begin
                if ((wq[d].size() < 3) && ($urandom_range(0, 1) == 1)) push_word(d, rand_word());
            end
            step_begin();
            scoreboard(c);
            step_end();
        end
        ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            left = 0;
            for (int d = 0; d < NDUT; d++) left += exp_q[d].size() + wq[d].size();
            if (left == 0) break;
            step_begin();
            scoreboard(1500 + c);
            step_end();
        end
        left = 0;
        for (int d = 0; d < NDUT; d++) left += exp_q[d].size() + wq[d].size();
        check_int("drain_left", left, 0);
    endtask

    task automatic checkOutput();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        sync_rst = 1'b1;
        ready    = 1'b1;
        p_ready  = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            p_valid[d] = 1'b0;
            p_last[d]  = 1'b0;
            p_data[d]  = '0;
            p_idx[d]   = 0;
        end
        drive_inputs();
        @(posedge clk);
        #1;
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
